// File: rtl/mips_ctrl_pkg.sv
// Shared types and encodings for the multicycle MIPS control unit.
// MCU_JUMP_EN: when defined, opcode 000010 dispatches to the JUMP state.
package mips_ctrl_pkg;

    localparam int unsigned OP_W = 6;

    localparam logic [OP_W-1:0] OP_RTYPE = 6'b000000;
    localparam logic [OP_W-1:0] OP_LW    = 6'b100011;
    localparam logic [OP_W-1:0] OP_SW    = 6'b101011;
    localparam logic [OP_W-1:0] OP_BEQ   = 6'b000100;
    localparam logic [OP_W-1:0] OP_ADDI  = 6'b001000;
    localparam logic [OP_W-1:0] OP_J     = 6'b000010;

    typedef enum logic [3:0] {
        S_IDLE,
        S_FETCH,
        S_DECODE,
        S_MEMADR,
        S_MEMRD,
        S_MEMWB,
        S_MEMWR,
        S_EXEC,
        S_RWB,
        S_BRANCH,
        S_ADDIEX,
        S_ADDIWB,
`ifdef MCU_JUMP_EN
        S_JUMP,
`endif
        S_ILLEGAL
    } state_e;

    typedef enum logic [1:0] {
        ALU_ADD   = 2'b00,
        ALU_SUB   = 2'b01,
        ALU_FUNCT = 2'b10
    } alu_op_e;

    typedef enum logic [1:0] {
        SRCB_REG     = 2'b00,
        SRCB_FOUR    = 2'b01,
        SRCB_IMM     = 2'b10,
        SRCB_IMM_SH2 = 2'b11
    } alu_srcb_e;

    typedef enum logic [1:0] {
        PC_ALU    = 2'b00,
        PC_ALUOUT = 2'b01,
        PC_JUMP   = 2'b10
    } pc_src_e;

    // Full set of datapath control lines for one cycle
    typedef struct packed {
        logic      mem_req;
        logic      iord;
        logic      mem_write;
        logic      ir_write;
        logic      reg_dst;
        logic      memto_reg;
        logic      reg_write;
        logic      alu_src_a;
        logic      branch;
        logic      pc_write;
        alu_srcb_e alu_src_b;
        alu_op_e   alu_op;
        pc_src_e   pc_src;
        logic      illegal_op;
    } ctrl_t;

    // State entered from DECODE for a given opcode
    function automatic state_e dispatch_state(input logic [OP_W-1:0] op);
        state_e s;
        s = S_ILLEGAL;
        case (op)
            OP_LW, OP_SW: s = S_MEMADR;
            OP_RTYPE:     s = S_EXEC;
            OP_BEQ:       s = S_BRANCH;
            OP_ADDI:      s = S_ADDIEX;
`ifdef MCU_JUMP_EN
            OP_J:         s = S_JUMP;
`endif
            default:      s = S_ILLEGAL;
        endcase
        return s;
    endfunction

endpackage

// File: rtl/multicycle_control_unit_if.sv
// Control-unit to datapath/memory bundle: opcode and memory ready in, controls out.
interface multicycle_control_unit_if import mips_ctrl_pkg::*; #(
    parameter int unsigned OPCODE_W = OP_W,
    parameter int unsigned CNT_W    = 32
);
    logic [OPCODE_W-1:0] OPCode;
    logic                mem_ready;
    logic                mem_req;
    logic                IorD;
    logic                MemWrite;
    logic                IRWrite;
    logic                RegDst;
    logic                MemtoReg;
    logic                RegWrite;
    logic                ALUSrcA;
    logic                Branch;
    logic                PCWrite;
    logic [1:0]          ALUSrcB;
    logic [1:0]          ALUop;
    logic [1:0]          PCSrc;
    logic                illegal_op;
    logic [CNT_W-1:0]    retired;

    modport master (
        input  OPCode, mem_ready,
        output mem_req, IorD, MemWrite, IRWrite, RegDst, MemtoReg, RegWrite,
               ALUSrcA, Branch, PCWrite, ALUSrcB, ALUop, PCSrc, illegal_op, retired
    );

    modport slave (
        output OPCode, mem_ready,
        input  mem_req, IorD, MemWrite, IRWrite, RegDst, MemtoReg, RegWrite,
               ALUSrcA, Branch, PCWrite, ALUSrcB, ALUop, PCSrc, illegal_op, retired
    );
endinterface

// File: rtl/mcu_out_decode.sv
// Combinational decode of FSM state (plus mem_ready in FETCH) into datapath controls.
// MCU_JUMP_EN: when defined, the JUMP state drives PCWrite with the jump target.
module mcu_out_decode import mips_ctrl_pkg::*; (
    input  state_e state,
    input  logic   mem_ready,
    output ctrl_t  ctrl_c
);

    // Per-state control values; everything not named is zero
    always_comb begin
        ctrl_c = '0;
        case (state)
            S_FETCH: begin
                ctrl_c.mem_req   = 1'b1;
                ctrl_c.alu_src_b = SRCB_FOUR;
                ctrl_c.ir_write  = mem_ready;
                ctrl_c.pc_write  = mem_ready;
            end
            S_DECODE: begin
                ctrl_c.alu_src_b = SRCB_IMM_SH2;
            end
            S_MEMADR: begin
                ctrl_c.alu_src_a = 1'b1;
                ctrl_c.alu_src_b = SRCB_IMM;
            end
            S_MEMRD: begin
                ctrl_c.mem_req = 1'b1;
                ctrl_c.iord    = 1'b1;
            end
            S_MEMWB: begin
                ctrl_c.reg_write = 1'b1;
                ctrl_c.memto_reg = 1'b1;
            end
            S_MEMWR: begin
                ctrl_c.mem_req   = 1'b1;
                ctrl_c.iord      = 1'b1;
                ctrl_c.mem_write = 1'b1;
            end
            S_EXEC: begin
                ctrl_c.alu_src_a = 1'b1;
                ctrl_c.alu_src_b = SRCB_REG;
                ctrl_c.alu_op    = ALU_FUNCT;
            end
            S_RWB: begin
                ctrl_c.reg_write = 1'b1;
                ctrl_c.reg_dst   = 1'b1;
            end
            S_BRANCH: begin
                ctrl_c.alu_src_a = 1'b1;
                ctrl_c.alu_src_b = SRCB_REG;
                ctrl_c.alu_op    = ALU_SUB;
                ctrl_c.branch    = 1'b1;
                ctrl_c.pc_src    = PC_ALUOUT;
            end
            S_ADDIEX: begin
                ctrl_c.alu_src_a = 1'b1;
                ctrl_c.alu_src_b = SRCB_IMM;
            end
            S_ADDIWB: begin
                ctrl_c.reg_write = 1'b1;
            end
`ifdef MCU_JUMP_EN
            S_JUMP: begin
                ctrl_c.pc_write = 1'b1;
                ctrl_c.pc_src   = PC_JUMP;
            end
`endif
            S_ILLEGAL: begin
                ctrl_c.illegal_op = 1'b1;
            end
            default: begin
                ctrl_c = '0;
            end
        endcase
    end

endmodule

// File: rtl/multicycle_control_unit.sv
// Multicycle MIPS control unit: state register, next-state logic, retire counter.
// MCU_JUMP_EN: when defined, opcode 000010 executes as a jump; otherwise it is illegal.
module multicycle_control_unit import mips_ctrl_pkg::*; #(
    parameter int unsigned OPCODE_W = OP_W,
    parameter int unsigned CNT_W    = 32
) (
    input  logic                       clk,
    input  logic                       reset,
    multicycle_control_unit_if.master  bus
);

    state_e              state_q, state_d;
    logic [CNT_W-1:0]    retired_q, retired_d;
    logic                retire_c;
    logic [OPCODE_W-1:0] opcode;
    ctrl_t               ctrl_c;

    assign opcode = bus.OPCode;

    // State register with synchronous reset
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state: memory states hold until mem_ready, others advance unconditionally
    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE:    state_d = S_FETCH;
            S_FETCH:   if (bus.mem_ready) state_d = S_DECODE;
            S_DECODE:  state_d = dispatch_state(opcode);
            S_MEMADR:  state_d = (opcode == OP_SW) ? S_MEMWR : S_MEMRD;
            S_MEMRD:   if (bus.mem_ready) state_d = S_MEMWB;
            S_MEMWB:   state_d = S_FETCH;
            S_MEMWR:   if (bus.mem_ready) state_d = S_FETCH;
            S_EXEC:    state_d = S_RWB;
            S_RWB:     state_d = S_FETCH;
            S_BRANCH:  state_d = S_FETCH;
            S_ADDIEX:  state_d = S_ADDIWB;
            S_ADDIWB:  state_d = S_FETCH;
`ifdef MCU_JUMP_EN
            S_JUMP:    state_d = S_FETCH;
`endif
            S_ILLEGAL: state_d = S_FETCH;
            default:   state_d = S_IDLE;
        endcase
    end

    // An instruction retires when a completing state hands back to FETCH
    always_comb begin
        retire_c = 1'b0;
        if (state_d == S_FETCH) begin
            case (state_q)
                S_MEMWB, S_MEMWR, S_RWB, S_BRANCH, S_ADDIWB: retire_c = 1'b1;
`ifdef MCU_JUMP_EN
                S_JUMP: retire_c = 1'b1;
`endif
                default: retire_c = 1'b0;
            endcase
        end
        retired_d = retired_q + CNT_W'(retire_c);
    end

    // Retired-instruction counter, wraps naturally
    always_ff @(posedge clk) begin
        if (reset) begin
            retired_q <= '0;
        end else begin
            retired_q <= retired_d;
        end
    end

    // Output decode of the current state
    mcu_out_decode u_out_decode (
        .state     (state_q),
        .mem_ready (bus.mem_ready),
        .ctrl_c    (ctrl_c)
    );

    assign bus.mem_req    = ctrl_c.mem_req;
    assign bus.IorD       = ctrl_c.iord;
    assign bus.MemWrite   = ctrl_c.mem_write;
    assign bus.IRWrite    = ctrl_c.ir_write;
    assign bus.RegDst     = ctrl_c.reg_dst;
    assign bus.MemtoReg   = ctrl_c.memto_reg;
    assign bus.RegWrite   = ctrl_c.reg_write;
    assign bus.ALUSrcA    = ctrl_c.alu_src_a;
    assign bus.Branch     = ctrl_c.branch;
    assign bus.PCWrite    = ctrl_c.pc_write;
    assign bus.ALUSrcB    = ctrl_c.alu_src_b;
    assign bus.ALUop      = ctrl_c.alu_op;
    assign bus.PCSrc      = ctrl_c.pc_src;
    assign bus.illegal_op = ctrl_c.illegal_op;
    assign bus.retired    = retired_q;

endmodule

// File: tb/tb_multicycle_control_unit.sv
// Scoreboard bench for multicycle_control_unit: a 32-bit and a 4-bit counter instance share stimulus.
module tb_multicycle_control_unit;

    logic clk = 1'b0;
    logic reset;

    always #5 clk = ~clk;

    multicycle_control_unit_if                bus32 ();
    multicycle_control_unit_if #(.CNT_W(4))   bus4 ();

    multicycle_control_unit dut32 (
        .clk   (clk),
        .reset (reset),
        .bus   (bus32.master)
    );

    multicycle_control_unit #(.CNT_W(4)) dut4 (
        .clk   (clk),
        .reset (reset),
        .bus   (bus4.master)
    );

    int unsigned n_cmp = 0;
    int unsigned n_mis = 0;
    int unsigned m_ret = 0;

    // Stimulus/expectation scoreboard, one entry per clock cycle
    logic        q_rst[$];
    logic        q_rdy[$];
    logic [5:0]  q_op[$];
    logic        q_rnd[$];
    logic [16:0] q_exp[$];
    string       q_tag[$];
    int unsigned q_ret[$];

    // Expected control vectors
    logic [16:0] E_IDLE, E_FETCH_W, E_FETCH_R, E_DECODE, E_MEMADR, E_MEMRD, E_MEMWB,
                 E_MEMWR, E_EXEC, E_RWB, E_BRANCH, E_ADDIEX, E_ADDIWB, E_JUMP, E_ILLEGAL;

    // {mem_req,IorD,MemWrite,IRWrite,RegDst,MemtoReg,RegWrite,ALUSrcA,Branch,PCWrite,ALUSrcB,ALUop,PCSrc,illegal_op}
    function automatic logic [16:0] ev(input bit req, input bit iord, input bit mw, input bit irw,
                                       input bit rdst, input bit m2r, input bit rw, input bit srca,
                                       input bit br, input bit pcw, input logic [1:0] srcb,
                                       input logic [1:0] aluop, input logic [1:0] pcsrc, input bit ill);
        return {req, iord, mw, irw, rdst, m2r, rw, srca, br, pcw, srcb, aluop, pcsrc, ill};
    endfunction

    function automatic logic rnd_bit();
        return 1'($urandom_range(0, 1));
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_mis++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic push(input logic rst, input logic rdy, input logic [5:0] op, input logic rnd,
                        input logic [16:0] e, input string tag);
        q_rst.push_back(rst);
        q_rdy.push_back(rdy);
        q_op.push_back(op);
        q_rnd.push_back(rnd);
        q_exp.push_back(e);
        q_tag.push_back(tag);
        q_ret.push_back(m_ret);
    endtask

    // Queue expected cycles of one instruction: wf fetch wait cycles, wm data-memory wait cycles
    task automatic push_instr(input logic [5:0] op, input int wf, input int wm, input string nm);
        for (int i = 0; i < wf; i++) push(1'b0, 1'b0, op, 1'b1, E_FETCH_W, {nm, ".fetch_wait"});
        push(1'b0, 1'b1, op, 1'b1, E_FETCH_R, {nm, ".fetch"});
        push(1'b0, rnd_bit(), op, 1'b0, E_DECODE, {nm, ".decode"});
        case (op)
            6'b100011: begin
                push(1'b0, rnd_bit(), op, 1'b0, E_MEMADR, {nm, ".memadr"});
                for (int i = 0; i < wm; i++) push(1'b0, 1'b0, op, 1'b0, E_MEMRD, {nm, ".memrd_wait"});
                push(1'b0, 1'b1, op, 1'b0, E_MEMRD, {nm, ".memrd"});
                push(1'b0, rnd_bit(), op, 1'b0, E_MEMWB, {nm, ".memwb"});
                m_ret++;
            end
            6'b101011: begin
                push(1'b0, rnd_bit(), op, 1'b0, E_MEMADR, {nm, ".memadr"});
                for (int i = 0; i < wm; i++) push(1'b0, 1'b0, op, 1'b0, E_MEMWR, {nm, ".memwr_wait"});
                push(1'b0, 1'b1, op, 1'b0, E_MEMWR, {nm, ".memwr"});
                m_ret++;
            end
            6'b000000: begin
                push(1'b0, rnd_bit(), op, 1'b0, E_EXEC, {nm, ".exec"});
                push(1'b0, rnd_bit(), op, 1'b0, E_RWB, {nm, ".rwb"});
                m_ret++;
            end
            6'b000100: begin
                push(1'b0, rnd_bit(), op, 1'b0, E_BRANCH, {nm, ".branch"});
                m_ret++;
            end
            6'b001000: begin
                push(1'b0, rnd_bit(), op, 1'b0, E_ADDIEX, {nm, ".addiex"});
                push(1'b0, rnd_bit(), op, 1'b0, E_ADDIWB, {nm, ".addiwb"});
                m_ret++;
            end
`ifdef MCU_JUMP_EN
            6'b000010: begin
                push(1'b0, rnd_bit(), op, 1'b0, E_JUMP, {nm, ".jump"});
                m_ret++;
            end
`endif
            default: begin
                push(1'b0, rnd_bit(), op, 1'b0, E_ILLEGAL, {nm, ".illegal"});
            end
        endcase
    endtask

    // Drain the scoreboard: drive one entry per cycle, compare at the falling edge
    task automatic run();
        logic        r, rdy, rnd;
        logic [5:0]  op;
        logic [16:0] e;
        string       tag;
        int unsigned er;
        while (q_exp.size() != 0) begin
            r   = q_rst.pop_front();
            rdy = q_rdy.pop_front();
            op  = q_op.pop_front();
            rnd = q_rnd.pop_front();
            e   = q_exp.pop_front();
            tag = q_tag.pop_front();
            er  = q_ret.pop_front();
            if (rnd) op = 6'($urandom);
            reset           = r;
            bus32.mem_ready = rdy;
            bus4.mem_ready  = rdy;
            bus32.OPCode    = op;
            bus4.OPCode     = op;
            @(negedge clk);
            chk({tag, ".ctl32"}, 32'({bus32.mem_req, bus32.IorD, bus32.MemWrite, bus32.IRWrite,
                 bus32.RegDst, bus32.MemtoReg, bus32.RegWrite, bus32.ALUSrcA, bus32.Branch,
                 bus32.PCWrite, bus32.ALUSrcB, bus32.ALUop, bus32.PCSrc, bus32.illegal_op}), 32'(e));
            chk({tag, ".ctl4"}, 32'({bus4.mem_req, bus4.IorD, bus4.MemWrite, bus4.IRWrite,
                 bus4.RegDst, bus4.MemtoReg, bus4.RegWrite, bus4.ALUSrcA, bus4.Branch,
                 bus4.PCWrite, bus4.ALUSrcB, bus4.ALUop, bus4.PCSrc, bus4.illegal_op}), 32'(e));
            chk({tag, ".retired32"}, bus32.retired, er);
            chk({tag, ".retired4"}, 32'(bus4.retired), 32'(4'(er)));
            @(posedge clk);
            #1;
        end
    endtask

    initial begin
        E_IDLE    = '0;
        E_FETCH_W = ev(1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 2'b01, 2'b00, 2'b00, 0);
        E_FETCH_R = ev(1, 0, 0, 1, 0, 0, 0, 0, 0, 1, 2'b01, 2'b00, 2'b00, 0);
        E_DECODE  = ev(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 2'b11, 2'b00, 2'b00, 0);
        E_MEMADR  = ev(0, 0, 0, 0, 0, 0, 0, 1, 0, 0, 2'b10, 2'b00, 2'b00, 0);
        E_MEMRD   = ev(1, 1, 0, 0, 0, 0, 0, 0, 0, 0, 2'b00, 2'b00, 2'b00, 0);
        E_MEMWB   = ev(0, 0, 0, 0, 0, 1, 1, 0, 0, 0, 2'b00, 2'b00, 2'b00, 0);
        E_MEMWR   = ev(1, 1, 1, 0, 0, 0, 0, 0, 0, 0, 2'b00, 2'b00, 2'b00, 0);
        E_EXEC    = ev(0, 0, 0, 0, 0, 0, 0, 1, 0, 0, 2'b00, 2'b10, 2'b00, 0);
        E_RWB     = ev(0, 0, 0, 0, 1, 0, 1, 0, 0, 0, 2'b00, 2'b00, 2'b00, 0);
        E_BRANCH  = ev(0, 0, 0, 0, 0, 0, 0, 1, 1, 0, 2'b00, 2'b01, 2'b01, 0);
        E_ADDIEX  = ev(0, 0, 0, 0, 0, 0, 0, 1, 0, 0, 2'b10, 2'b00, 2'b00, 0);
        E_ADDIWB  = ev(0, 0, 0, 0, 0, 0, 1, 0, 0, 0, 2'b00, 2'b00, 2'b00, 0);
        E_JUMP    = ev(0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 2'b00, 2'b00, 2'b10, 0);
        E_ILLEGAL = ev(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 2'b00, 2'b00, 2'b00, 1);

        // Power-up: hold reset for two edges before checking
        reset           = 1'b1;
        bus32.mem_ready = 1'b0;
        bus4.mem_ready  = 1'b0;
        bus32.OPCode    = '0;
        bus4.OPCode     = '0;
        repeat (2) @(posedge clk);
        #1;

        // Reset held 3 more cycles, then the IDLE cycle after release
        m_ret = 0;
        for (int i = 0; i < 3; i++) push(1'b1, rnd_bit(), 6'h00, 1'b1, E_IDLE, "reset");
        push(1'b0, rnd_bit(), 6'h00, 1'b1, E_IDLE, "idle");
        run();

        // lw with no wait states
        push_instr(6'b100011, 0, 0, "lw0");
        run();

        // sw with 3 wait cycles in MEMWR
        push_instr(6'b101011, 0, 3, "sw3");
        run();

        // R-type followed by beq
        push_instr(6'b000000, 0, 0, "rtype");
        push_instr(6'b000100, 0, 0, "beq");
        run();

        // Unsupported opcode, then the jump opcode
        push_instr(6'b111111, 0, 0, "ill3f");
        push_instr(6'b000010, 0, 0, "jmp");
        run();

        // Fetch and data-memory wait states
        push_instr(6'b001000, 2, 0, "addi_fw");
        push_instr(6'b100011, 1, 2, "lw_w");
        push_instr(6'b000010, 1, 0, "jmp_fw");
        run();

        // Reset asserted while lw sits in MEMRD
        push(1'b0, 1'b1, 6'b100011, 1'b1, E_FETCH_R, "abort.fetch");
        push(1'b0, rnd_bit(), 6'b100011, 1'b0, E_DECODE, "abort.decode");
        push(1'b0, rnd_bit(), 6'b100011, 1'b0, E_MEMADR, "abort.memadr");
        push(1'b0, 1'b0, 6'b100011, 1'b0, E_MEMRD, "abort.memrd");
        push(1'b1, 1'b0, 6'b100011, 1'b0, E_MEMRD, "abort.rst");
        m_ret = 0;
        push(1'b0, rnd_bit(), 6'b100011, 1'b0, E_IDLE, "abort.idle");
        run();

        // 17 addi: the 4-bit counter wraps to 1
        for (int i = 0; i < 17; i++) push_instr(6'b001000, 0, 0, "addi_wrap");
        push_instr(6'b000100, 0, 0, "beq_after_wrap");
        run();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
        $finish;
    end

endmodule
